// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// flush counter width and the NOP instruction loaded into flushed registers.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int          FLUSH_CNT_W = 3;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

   // One-hot-free bundle of the per-cycle control outputs.
   typedef struct packed {
      logic jump_en;
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic if_id_flush;
      logic id_ex_flush;
   } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating up-counter with increment enable and synchronous clear.
module sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves jumps, multi-cycle EX stalls and
// load-use bubbles into PC/IF-ID/ID-EX stall and flush controls.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_req_i,
   input  logic [31:0] jump_addr_i,
   input  logic        ex_busy_i,
   input  logic        load_use_i,
   output logic        jump_en_o,
   output logic [31:0] jump_addr_o,
   output logic        pc_stall_o,
   output logic        if_id_stall_o,
   output logic        id_ex_stall_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic [15:0] stall_cycles_o
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   state_t                 state_reg, state_next;
   logic [FLUSH_CNT_W-1:0] cnt_reg, cnt_next;
   ctrl_t                  ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RUN;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      ctrl       = '0;
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_RUN, ST_BUSY: begin
            if ((state_reg == ST_BUSY) && ex_busy_i) begin
               ctrl.pc_stall    = 1'b1;
               ctrl.if_id_stall = 1'b1;
               ctrl.id_ex_stall = 1'b1;
               state_next       = ST_BUSY;
            end else if (jump_req_i) begin
               // Redirect now; the remaining wrong-path slots are flushed in FLUSH.
               ctrl.jump_en     = 1'b1;
               ctrl.if_id_flush = 1'b1;
               ctrl.id_ex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_next = ST_FLUSH;
                  cnt_next   = FLUSH_LOAD;
               end else begin
                  state_next = ST_RUN;
               end
            end else if (ex_busy_i) begin
               ctrl.pc_stall    = 1'b1;
               ctrl.if_id_stall = 1'b1;
               ctrl.id_ex_stall = 1'b1;
               state_next       = ST_BUSY;
            end else if (load_use_i) begin
               // Hold the dependent instruction in ID and inject one bubble.
               ctrl.pc_stall    = 1'b1;
               ctrl.if_id_stall = 1'b1;
               ctrl.id_ex_flush = 1'b1;
               state_next       = ST_RUN;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_FLUSH: begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            cnt_next         = cnt_reg - 1'b1;
            if (cnt_reg <= FLUSH_CNT_W'(1)) begin
               state_next = ST_RUN;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = ST_RUN;
            cnt_next   = '0;
         end
      endcase
      if (rst) begin
         ctrl = '0;
      end
   end

   assign jump_en_o     = ctrl.jump_en;
   assign jump_addr_o   = ctrl.jump_en ? jump_addr_i : 32'h0;
   assign pc_stall_o    = ctrl.pc_stall;
   assign if_id_stall_o = ctrl.if_id_stall;
   assign id_ex_stall_o = ctrl.id_ex_stall;
   assign if_id_flush_o = ctrl.if_id_flush;
   assign id_ex_flush_o = ctrl.id_ex_flush;

   sat_cnt #(
      .WIDTH(16)
   ) u_stall_cnt (
      .clk  (clk),
      .clr  (rst),
      .inc  (ctrl.pc_stall),
      .count(stall_cycles_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with FLUSH_CYCLES=2.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_req_i;
   logic [31:0] jump_addr_i;
   logic        ex_busy_i;
   logic        load_use_i;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        pc_stall_o;
   logic        if_id_stall_o;
   logic        id_ex_stall_o;
   logic        if_id_flush_o;
   logic        id_ex_flush_o;
   logic [15:0] stall_cycles_o;

   int errors = 0;
   int checks = 0;

   // {jump_en, pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush}
   localparam logic [5:0] C_IDLE  = 6'b000000;
   localparam logic [5:0] C_JUMP  = 6'b100011;
   localparam logic [5:0] C_FLUSH = 6'b000011;
   localparam logic [5:0] C_BUSY  = 6'b011100;
   localparam logic [5:0] C_LOAD  = 6'b011001;

   logic [5:0] ctrl_obs;
   assign ctrl_obs = {jump_en_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
                      if_id_flush_o, id_ex_flush_o};

   pipe_ctrl #(
      .FLUSH_CYCLES(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jump_req_i    (jump_req_i),
      .jump_addr_i   (jump_addr_i),
      .ex_busy_i     (ex_busy_i),
      .load_use_i    (load_use_i),
      .jump_en_o     (jump_en_o),
      .jump_addr_o   (jump_addr_o),
      .pc_stall_o    (pc_stall_o),
      .if_id_stall_o (if_id_stall_o),
      .id_ex_stall_o (id_ex_stall_o),
      .if_id_flush_o (if_id_flush_o),
      .id_ex_flush_o (id_ex_flush_o),
      .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("[%0t] %s observed=%h expected=%h", $time, tag, obs, exp);
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Apply inputs for this cycle and let combinational outputs settle.
   task automatic drive(input logic r, input logic j, input logic [31:0] a,
                        input logic b, input logic l);
      rst         = r;
      jump_req_i  = j;
      jump_addr_i = a;
      ex_busy_i   = b;
      load_use_i  = l;
      #3;
   endtask

   task automatic chk_cycle(input string tag, input logic [5:0] ctrl_exp,
                            input logic [31:0] addr_exp);
      chk({tag, "_ctrl"}, {26'h0, ctrl_obs}, {26'h0, ctrl_exp});
      chk({tag, "_addr"}, jump_addr_o, addr_exp);
   endtask

   initial begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      next();
      // Reset forces outputs low even with active requests.
      drive(1'b1, 1'b1, 32'h0000_0AAA, 1'b1, 1'b1);
      chk_cycle("rst_force", C_IDLE, 32'h0);
      next();
      chk("rst_cnt", {16'h0, stall_cycles_o}, 32'h0);

      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("idle", C_IDLE, 32'h0);
      next();

      // Taken jump: redirect cycle, one extra flush cycle, then idle.
      drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      chk_cycle("jump0", C_JUMP, 32'h0000_0100);
      next();
      drive(1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      chk_cycle("jump1", C_FLUSH, 32'h0);
      next();
      chk_cycle("jump2", C_IDLE, 32'h0);
      next();

      // Load-use bubble for exactly one cycle.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_cycle("lu0", C_LOAD, 32'h0);
      chk("lu0_cnt", {16'h0, stall_cycles_o}, 32'h0);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("lu1", C_IDLE, 32'h0);
      chk("lu1_cnt", {16'h0, stall_cycles_o}, 32'h1);
      next();

      // FLUSH ignores every request.
      drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
      chk_cycle("fi0", C_JUMP, 32'h0000_0200);
      next();
      drive(1'b0, 1'b1, 32'h0000_0204, 1'b1, 1'b1);
      chk_cycle("fi1", C_FLUSH, 32'h0);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("fi2", C_IDLE, 32'h0);
      next();

      // Five busy cycles (requests ignored while busy), then completion with a jump.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, (i >= 2), 32'h0000_0BAD, 1'b1, (i == 3));
         chk_cycle($sformatf("busy%0d", i), C_BUSY, 32'h0);
         next();
      end
      drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
      chk_cycle("bdone", C_JUMP, 32'h0000_0300);
      chk("bdone_cnt", {16'h0, stall_cycles_o}, 32'h6);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("bdone1", C_FLUSH, 32'h0);
      next();
      chk_cycle("bdone2", C_IDLE, 32'h0);
      chk("bdone2_cnt", {16'h0, stall_cycles_o}, 32'h6);
      next();

      // All three requests in RUN: jump wins.
      drive(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
      chk_cycle("all0", C_JUMP, 32'h0000_0400);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("all1", C_FLUSH, 32'h0);
      chk("all1_cnt", {16'h0, stall_cycles_o}, 32'h6);
      next();

      // Reset during the FLUSH cycle.
      drive(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
      chk_cycle("rf0", C_JUMP, 32'h0000_0500);
      next();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("rf1", C_IDLE, 32'h0);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("rf2", C_IDLE, 32'h0);
      chk("rf2_cnt", {16'h0, stall_cycles_o}, 32'h0);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk_cycle("rf3", C_LOAD, 32'h0);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("rf4", C_IDLE, 32'h0);
      chk("rf4_cnt", {16'h0, stall_cycles_o}, 32'h1);
      next();

      // Reset during BUSY clears the counter and drops stalls.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_cycle("rb0", C_BUSY, 32'h0);
      next();
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_cycle("rb1", C_IDLE, 32'h0);
      next();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_cycle("rb2", C_IDLE, 32'h0);
      chk("rb2_cnt", {16'h0, stall_cycles_o}, 32'h0);
      next();

      // Long stall: counter reaches 16'hFFFF and stays there.
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      repeat (65534) next();
      chk("sat_fffe", {16'h0, stall_cycles_o}, 32'h0000_FFFE);
      next();
      chk("sat_ffff", {16'h0, stall_cycles_o}, 32'h0000_FFFF);
      repeat (4465) next();
      chk("sat_hold", {16'h0, stall_cycles_o}, 32'h0000_FFFF);
      chk_cycle("sat_ctrl", C_BUSY, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
